// File: rtl/mem_loader.sv
// mem_loader: streams a little-endian header (address lo/hi, length lo/hi)
// followed by `length` data bytes, and writes each data byte to memory at
// consecutive addresses, one cycle after the byte is accepted.
//
// Optional feature: define MEM_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of all data bytes); a mismatch sets the sticky error flag.
// With the macro undefined, no trailing byte is consumed and error is tied to 0.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   start          one-cycle load request, honoured only while idle
//   in_valid       stream byte valid
//   in_data        stream byte
//   in_ready       stream byte accept (high in header/data/check states)
//   mem_wr_enable  memory write strobe
//   mem_addr       memory write address (holds when no write)
//   mem_wr_data    memory write data (holds when no write)
//   busy           high while a load is in progress
//   done           one-cycle pulse when a load completes
//   error          sticky checksum-failure flag, cleared by an accepted start
module mem_loader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_wr_enable,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   // Header fields are two stream bytes wide.
   localparam int unsigned HdrWidth = 2 * DATA_WIDTH;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StAddrLo = 3'd1;
   localparam logic [2:0] StAddrHi = 3'd2;
   localparam logic [2:0] StLenLo  = 3'd3;
   localparam logic [2:0] StLenHi  = 3'd4;
   localparam logic [2:0] StData   = 3'd5;
   localparam logic [2:0] StFinish = 3'd7;
`ifdef MEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] StCheck  = 3'd6;
   // State entered once the data phase (or an empty load) is over.
   localparam logic [2:0] StEnd    = StCheck;
`else
   localparam logic [2:0] StEnd    = StFinish;
`endif

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] hdr_lo_q, hdr_lo_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [HdrWidth-1:0]   cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_q, xor_d;
   logic                  error_q, error_d;
`endif

   logic                  xfer;
   logic [HdrWidth-1:0]   hdr_word;
   logic [ADDR_WIDTH-1:0] hdr_addr;

   assign xfer     = in_valid & in_ready;
   // The current byte is the high half; the low half was captured last transfer.
   assign hdr_word = {in_data, hdr_lo_q};

   // Fit the two-byte header address to the configured address width.
   if (ADDR_WIDTH <= HdrWidth) begin : g_addr_trunc
      assign hdr_addr = hdr_word[ADDR_WIDTH-1:0];
   end else begin : g_addr_ext
      assign hdr_addr = {{(ADDR_WIDTH - HdrWidth){1'b0}}, hdr_word};
   end

   always_comb begin
      state_d   = state_q;
      hdr_lo_d  = hdr_lo_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef MEM_LOADER_CHECKSUM_EN
      xor_d     = xor_q;
      error_d   = error_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StAddrLo;
`ifdef MEM_LOADER_CHECKSUM_EN
               xor_d   = '0;
               error_d = 1'b0;
`endif
            end
         end
         StAddrLo: begin
            if (xfer) begin
               hdr_lo_d = in_data;
               state_d  = StAddrHi;
            end
         end
         StAddrHi: begin
            if (xfer) begin
               addr_d  = hdr_addr;
               state_d = StLenLo;
            end
         end
         StLenLo: begin
            if (xfer) begin
               hdr_lo_d = in_data;
               state_d  = StLenHi;
            end
         end
         StLenHi: begin
            if (xfer) begin
               cnt_d   = hdr_word;
               // An empty load skips the data phase entirely.
               state_d = (hdr_word == '0) ? StEnd : StData;
            end
         end
         StData: begin
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = in_data;
               addr_d    = addr_q + ADDR_WIDTH'(1);
               cnt_d     = cnt_q - HdrWidth'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
               xor_d     = xor_q ^ in_data;
`endif
               if (cnt_q == HdrWidth'(1)) begin
                  state_d = StEnd;
               end
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         StCheck: begin
            if (xfer) begin
               if (in_data != xor_q) begin
                  error_d = 1'b1;
               end
               state_d = StFinish;
            end
         end
`endif
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         hdr_lo_q  <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
         xor_q     <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hdr_lo_q  <= hdr_lo_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
         xor_q     <= xor_d;
         error_q   <= error_d;
`endif
      end
   end

   assign in_ready      = (state_q != StIdle) && (state_q != StFinish);
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StFinish);
   assign mem_wr_enable = wr_en_q;
   assign mem_addr      = wr_addr_q;
   assign mem_wr_data   = wr_data_q;
`ifdef MEM_LOADER_CHECKSUM_EN
   assign error         = error_q;
`else
   assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table-driven directed loads, random
// loads against a queue-based reference model, and hand-written reset and
// checksum sequences. Works with MEM_LOADER_CHECKSUM_EN defined or not.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_wr_enable;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wr_data;
   logic        busy;
   logic        done;
   logic        error;

   mem_loader #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_wr_enable(mem_wr_enable),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned addr;
      int unsigned data;
      int          cyc;
   } wr_t;

   typedef struct packed {
      logic [15:0]      addr;
      logic [7:0]       len;
      logic [3:0][7:0]  d;
      logic [7:0]       chk;
      logic [3:0][15:0] ea;
      logic [3:0][7:0]  ed;
      logic             eerr;
   } vec_t;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  last_xfer = 0;
   wr_t wlog[$];
   int  dcyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs away from the active edge.
   always @(negedge clk) begin
      if (mem_wr_enable) wlog.push_back('{32'(mem_addr), 32'(mem_wr_data), cyc});
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall, input bit is_data,
                            input bit rnd_start);
      int guard = 0;
      bit sent = 1'b0;
      while (!sent) begin
         @(negedge clk);
         start = rnd_start ? ($urandom_range(1, 0) == 1) : 1'b0;
         if (stall > 0 && $urandom_range(99, 0) < stall) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
               sent      = 1'b1;
               last_xfer = cyc + 1;
               if (is_data) dcyc.push_back(cyc + 1);
            end
         end
         guard++;
         if (!sent && guard > 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never seen, byte %0h", b);
            sent = 1'b1;
         end
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic run_load(input string nm, input logic [15:0] addr, input logic [7:0] d[$],
                           input logic [7:0] chk, input int stall, input bit rs,
                           input wr_t ex[$], input bit eerr);
      logic [7:0]  s[$];
      logic [15:0] ln;
      int          w;
      wlog.delete();
      dcyc.delete();
      done_cnt = 0;
      ln = 16'(d.size());
      s.push_back(addr[7:0]);
      s.push_back(addr[15:8]);
      s.push_back(ln[7:0]);
      s.push_back(ln[15:8]);
      foreach (d[i]) s.push_back(d[i]);
`ifdef MEM_LOADER_CHECKSUM_EN
      s.push_back(chk);
`endif
      do_start();
      foreach (s[i]) begin
         send_byte(s[i], stall, (i >= 4) && (i < 4 + d.size()), rs && (i != s.size() - 1));
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      w = 0;
      while (busy && w < 10) begin
         if (done) begin
            check({nm, " done_busy"}, busy, 1);
            check({nm, " done_ready"}, in_ready, 0);
         end
         @(negedge clk);
         w++;
      end
      check({nm, " idle_after"}, busy, 0);
      repeat (3) @(negedge clk);
      #1;
      check({nm, " n_writes"}, wlog.size(), ex.size());
      foreach (ex[i]) begin
         if (i < wlog.size()) begin
            check({nm, " wr_addr"}, wlog[i].addr, ex[i].addr);
            check({nm, " wr_data"}, wlog[i].data, ex[i].data);
            if (i < dcyc.size()) check({nm, " wr_latency"}, wlog[i].cyc, dcyc[i]);
         end
      end
      check({nm, " done_pulses"}, done_cnt, 1);
      check({nm, " done_lat"}, ((done_cyc - last_xfer) >= 0) && ((done_cyc - last_xfer) <= 2), 1);
      check({nm, " error"}, error, eerr);
      if (ex.size() > 0) begin
         check({nm, " addr_hold"}, mem_addr, ex[ex.size() - 1].addr);
         check({nm, " data_hold"}, mem_wr_data, ex[ex.size() - 1].data);
      end
   endtask

   vec_t       vt[$];
   logic [7:0] dq[$];
   wr_t        eq[$];
   logic [7:0] x;
   logic [15:0] ra;
   int         rl;
   bit         bad;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("rst in_ready", in_ready, 0);
      check("rst wr_en", mem_wr_enable, 0);
      check("rst addr", mem_addr, 0);
      check("rst data", mem_wr_data, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst error", error, 0);
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors: header/data inputs with spec-derived expected writes.
      vt.push_back({16'h0200, 8'd3, {8'h00, 8'h8D, 8'h01, 8'hA9}, 8'h25,
                    {16'h0, 16'h0202, 16'h0201, 16'h0200}, {8'h00, 8'h8D, 8'h01, 8'hA9}, 1'b0});
      vt.push_back({16'hFFFF, 8'd2, {8'h00, 8'h00, 8'h22, 8'h11}, 8'h33,
                    {16'h0, 16'h0, 16'h0000, 16'hFFFF}, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b0});
      vt.push_back({16'h1000, 8'd0, 32'h0, 8'h00, 64'h0, 32'h0, 1'b0});
`ifdef MEM_LOADER_CHECKSUM_EN
      vt.push_back({16'h3000, 8'd2, {8'h00, 8'h00, 8'hF0, 8'h0F}, 8'hFF,
                    {16'h0, 16'h0, 16'h3001, 16'h3000}, {8'h00, 8'h00, 8'hF0, 8'h0F}, 1'b0});
      vt.push_back({16'h3000, 8'd2, {8'h00, 8'h00, 8'hF0, 8'h0F}, 8'h00,
                    {16'h0, 16'h0, 16'h3001, 16'h3000}, {8'h00, 8'h00, 8'hF0, 8'h0F}, 1'b1});
`endif
      foreach (vt[k]) begin
         dq.delete();
         eq.delete();
         for (int i = 0; i < int'(vt[k].len); i++) begin
            dq.push_back(vt[k].d[i]);
            eq.push_back('{32'(vt[k].ea[i]), 32'(vt[k].ed[i]), 0});
         end
         run_load($sformatf("vec%0d", k), vt[k].addr, dq, vt[k].chk, 0, 1'b0, eq, vt[k].eerr);
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      // Error from the last vector stays set while idle, then clears on a new load.
      repeat (4) @(negedge clk);
      #1;
      check("err_sticky", error, 1);
      dq.delete();
      eq.delete();
      run_load("err_clear", 16'h4000, dq, 8'h00, 0, 1'b0, eq, 1'b0);
`endif

      // Basic load again with stalls and start toggling while busy.
      dq = '{8'hA9, 8'h01, 8'h8D};
      eq = '{'{32'h0200, 32'hA9, 0}, '{32'h0201, 32'h01, 0}, '{32'h0202, 32'h8D, 0}};
      run_load("stall", 16'h0200, dq, 8'h25, 40, 1'b1, eq, 1'b0);

      // Reset right after the 2nd data byte of a 4-byte load, with a 3rd byte offered.
      wlog.delete();
      dcyc.delete();
      do_start();
      send_byte(8'h00, 0, 1'b0, 1'b0);
      send_byte(8'h05, 0, 1'b0, 1'b0);
      send_byte(8'h04, 0, 1'b0, 1'b0);
      send_byte(8'h00, 0, 1'b0, 1'b0);
      send_byte(8'hA1, 0, 1'b1, 1'b0);
      send_byte(8'hA2, 0, 1'b1, 1'b0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA3;
      @(negedge clk);
      #1;
      check("mid_rst writes", wlog.size(), 2);
      check("mid_rst in_ready", in_ready, 0);
      check("mid_rst wr_en", mem_wr_enable, 0);
      check("mid_rst addr", mem_addr, 0);
      check("mid_rst data", mem_wr_data, 0);
      check("mid_rst busy", busy, 0);
      check("mid_rst done", done, 0);
      check("mid_rst error", error, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("post_rst writes", wlog.size(), 2);
      run_load("after_rst", 16'h0200, dq, 8'h25, 0, 1'b0, eq, 1'b0);

      // Random loads checked against a simple address/data model.
      for (int k = 0; k < 8; k++) begin
         ra = (k % 2 == 1) ? 16'(16'hFFFF - $urandom_range(3, 0)) : 16'($urandom);
         rl = $urandom_range(6, 0);
         dq.delete();
         eq.delete();
         x = 8'h00;
         for (int i = 0; i < rl; i++) begin
            dq.push_back(8'($urandom));
            x = x ^ dq[i];
            eq.push_back('{(32'(ra) + 32'(i)) % 32'h10000, 32'(dq[i]), 0});
         end
         bad = ($urandom_range(2, 0) == 0);
`ifdef MEM_LOADER_CHECKSUM_EN
         run_load($sformatf("rnd%0d", k), ra, dq, bad ? (x ^ 8'h5A) : x, 30, 1'b1, eq, bad);
`else
         run_load($sformatf("rnd%0d", k), ra, dq, bad ? (x ^ 8'h5A) : x, 30, 1'b1, eq, 1'b0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the byte width of the input stream and memory write data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, the memory address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 The block SHALL have port in_valid, input, 1, the stream byte-valid signal.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH, the stream byte.
REQ-008 The block SHALL have port in_ready, output, 1, the stream byte-accept signal.
REQ-009 The block SHALL have port mem_wr_enable, output, 1, the memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, ADDR_WIDTH, the memory write address.
REQ-011 The block SHALL have port mem_wr_data, output, DATA_WIDTH, the memory write data.
REQ-012 The block SHALL have port busy, output, 1, which is high while a load is in progress.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when a load completes.
REQ-014 The block SHALL have port error, output, 1, a sticky load-failure flag.

Function
REQ-015 A byte SHALL transfer on a cycle where in_valid and in_ready are both high; in_data SHALL be ignored on all other cycles.
REQ-016 The FSM SHALL have states IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CHECK and FINISH.
REQ-017 In IDLE, the FSM SHALL move to ADDR_LO on start=1; start SHALL be ignored in every other state.
REQ-018 The header states SHALL run ADDR_LO->ADDR_HI->LEN_LO->LEN_HI, advancing one state per transferred byte, with address and length captured little-endian.
REQ-019 On leaving LEN_HI, the FSM SHALL go to DATA if length!=0; if length==0 it SHALL go to CHECK (macro defined) or FINISH (macro undefined), and no memory write SHALL occur.
REQ-020 In DATA, each transferred byte SHALL produce exactly one write: on the next cycle mem_wr_enable=1, mem_addr=current address, mem_wr_data=byte (1-cycle latency).
REQ-021 After each data transfer, the address SHALL increment modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000) and the remaining count SHALL decrement.
REQ-022 When the count reaches 0, DATA SHALL exit to CHECK (macro defined) or FINISH (macro undefined).
REQ-023 in_ready SHALL be 1 in ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA and CHECK, and 0 in IDLE and FINISH.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 FINISH SHALL last one cycle, during which done=1, and SHALL then return to IDLE.
REQ-026 mem_wr_enable SHALL be 0 on every cycle except those defined in REQ-020; mem_addr and mem_wr_data SHALL hold their last values when no write occurs.
REQ-027 error SHALL clear when start is accepted in IDLE and SHALL otherwise hold until reset.
REQ-028 Stalls SHALL be supported: in_valid low for any number of cycles in any state SHALL pause the FSM without side effects.

Reset
REQ-029 Reset SHALL put the FSM in IDLE and drive in_ready=0, mem_wr_enable=0, mem_addr=0, mem_wr_data=0, busy=0, done=0 and error=0.
REQ-030 Reset asserted mid-load SHALL abort the load on the next edge; any write pending from the previous cycle SHALL be suppressed.

Configuration
REQ-031 The macro MEM_LOADER_CHECKSUM_EN SHALL control a trailing checksum byte.
REQ-032 With MEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all data bytes, cleared when start is accepted, and CHECK SHALL accept one byte, setting error=1 if that byte differs from the XOR, then go to FINISH.
REQ-033 With MEM_LOADER_CHECKSUM_EN undefined, the CHECK state and the XOR logic SHALL be absent, error SHALL be constant 0, and no trailing byte SHALL be consumed.

Verification
REQ-034 The bench SHALL cover a basic load: start, then stream 00 02 03 00 A9 01 8D -> writes 0x0200=A9, 0x0201=01, 0x0202=8D, one cycle after each byte, and done pulses once.
REQ-035 The bench SHALL cover wrap-around: header FF FF 02 00, data 11 22 -> writes 0xFFFF=11 and 0x0000=22.
REQ-036 The bench SHALL cover zero length: header 00 10 00 00 -> no mem_wr_enable pulse and done within 2 cycles of the last header byte.
REQ-037 The bench SHALL cover the checksum (macro defined): data 0F F0 with checksum FF gives error=0; with checksum 00 it gives error=1, held until the next start.
REQ-038 The bench SHALL cover random in_valid stalls plus start pulsed while busy -> the write sequence is identical to the unstalled run and the extra start is ignored.
REQ-039 The bench SHALL cover reset asserted after the 2nd data byte of a 4-byte load -> no further writes, all outputs at reset values, and a following load succeeds.
